// File: rtl/temp_stim_pkg.sv
// Shared types, constants and helpers for the temp stimulus generator.
package temp_stim_pkg;

  typedef enum logic [1:0] {COUNT, WALK, LFSR, ZERO} mode_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One Galois step: shift right, fold the taps in when a 1 falls out.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // A zero seed would lock the LFSR at zero, so it is replaced by 1.
  function automatic logic [15:0] seed_fix(input logic [15:0] s);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  // Walking one: 1000 rotated right by k mod 4.
  function automatic logic [3:0] walk_vec(input logic [1:0] k);
    return 4'b1000 >> k;
  endfunction

  // The emitted LFSR vector is the low nibble of the state.
  function automatic logic [3:0] lfsr_vec(input logic [15:0] s);
    return s[3:0];
  endfunction

endpackage

// File: rtl/temp_stim_lfsr.sv
// 16-bit Galois LFSR that steps only when asked; it keeps its state
// across bursts and is reseeded only by reset.
module temp_stim_lfsr
  import temp_stim_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  output logic [15:0] q
);

  localparam logic [15:0] INIT = seed_fix(SEED);

  // State register: reseed on reset, otherwise advance one step per request.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= INIT;
    end else if (adv) begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/temp_stim_gen.sv
// Burst stimulus generator for the temp block: emits len vectors in one of
// four patterns after a start request, then a one-cycle done pulse.
// All outputs are registered. LEN_W must be at least 4.
module temp_stim_gen
  import temp_stim_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [LEN_W-1:0] len,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_e           state;
  state_e           state_next;
  mode_e            mode_q;
  mode_e            mode_next;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_next;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_next;
  logic             emit;
  mode_e            emit_mode;
  logic [3:0]       emit_k;
  logic             done_next;
  logic [3:0]       vec;
  logic [3:0]       vec_q;
  logic [15:0]      lfsr_q;
  logic             lfsr_adv;

  temp_stim_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .adv (lfsr_adv),
    .q   (lfsr_q)
  );

  // Next-state logic: decides whether a vector is emitted this edge, which
  // pattern and index it uses, and how the counter and latches move.
  always_comb begin
    state_next = state;
    mode_next  = mode_q;
    len_next   = len_q;
    cnt_next   = cnt;
    emit       = 1'b0;
    emit_mode  = mode_q;
    emit_k     = cnt[3:0];
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          mode_next = mode_e'(mode);
          len_next  = len;
          if (len == '0) begin
            state_next = DONE;
            done_next  = 1'b1;
            cnt_next   = '0;
          end else begin
            emit       = 1'b1;
            emit_mode  = mode_e'(mode);
            emit_k     = 4'd0;
            cnt_next   = ONE;
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (cnt == len_q) begin
          state_next = DONE;
          done_next  = 1'b1;
        end else begin
          emit     = 1'b1;
          cnt_next = cnt + ONE;
        end
      end
      DONE: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Pattern selection for the vector about to be emitted.
  always_comb begin
    vec = 4'h0;
    case (emit_mode)
      COUNT:   vec = emit_k;
      WALK:    vec = walk_vec(emit_k[1:0]);
      LFSR:    vec = lfsr_vec(lfsr_q);
      ZERO:    vec = 4'h0;
      default: vec = 4'h0;
    endcase
  end

  assign lfsr_adv = emit && (emit_mode == LFSR);

  // State, counter, burst latches and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mode_q <= COUNT;
      len_q  <= '0;
      cnt    <= '0;
      vec_q  <= 4'h0;
      valid  <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      mode_q <= mode_next;
      len_q  <= len_next;
      cnt    <= cnt_next;
      vec_q  <= emit ? vec : 4'h0;
      valid  <= emit;
      done   <= done_next;
    end
  end

  assign {a, b, c, d} = vec_q;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_temp_stim_gen.sv
// Scoreboard testbench for temp_stim_gen: the driver pushes expected vectors
// from a pattern model and checks cycle timing; a monitor pops on valid.
module tb_temp_stim_gen;

  localparam int          LEN_W = 8;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       mode;
  logic [LEN_W-1:0] len;
  logic             a, b, c, d;
  logic             valid, busy, done;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  mon_exp;
  logic [15:0] lfsr_m;

  temp_stim_gen #(
    .SEED  (SEED),
    .LEN_W (LEN_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .len   (len),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .valid (valid),
    .busy  (busy),
    .done  (done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [15:0] model_step(input logic [15:0] s);
    logic [15:0] r;
    r = s / 16'd2;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    n_vec++;
    if (actual !== required) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, required, $time);
    end
  endtask

  // Reference model: the sequence of vectors a burst should produce.
  task automatic push_burst(input logic [1:0] m, input int l);
    logic [3:0] v;
    for (int k = 0; k < l; k++) begin
      case (m)
        2'd0: v = 4'(k % 16);
        2'd1: v = 4'(8 >> (k % 4));
        2'd2: begin
          v      = lfsr_m[3:0];
          lfsr_m = model_step(lfsr_m);
        end
        default: v = 4'h0;
      endcase
      exp_q.push_back(v);
    end
  endtask

  // Monitor: every valid vector must match the next expected one; idle data is zero.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("vec_unexpected", 32'(valid), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("vec", 32'({a, b, c, d}), 32'(mon_exp));
      end
    end else begin
      checkOutput("idle_vec", 32'({a, b, c, d}), 32'd0);
    end
  end

  // Issue one burst at the current negedge and check timing cycle by cycle.
  task automatic applyStimulus(input logic [1:0] m, input int l, input bit poke);
    start = 1'b1;
    mode  = m;
    len   = LEN_W'(l);
    push_burst(m, l);
    for (int i = 0; i <= l; i++) begin
      @(negedge clk);
      start = 1'b0;
      mode  = 2'($urandom);
      len   = LEN_W'($urandom);
      checkOutput("valid", 32'(valid), 32'(i < l));
      checkOutput("done", 32'(done), 32'(i == l));
      checkOutput("busy", 32'(busy), 32'd1);
      if (poke && i == 2 && l > 3) start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_done", 32'(done), 32'd0);
    checkOutput("idle_valid", 32'(valid), 32'd0);
  endtask

  task automatic check_quiet(input string name);
    checkOutput(name, 32'({a, b, c, d, valid, busy, done}), 32'd0);
  endtask

  // Reset during cycle 3 of a 10-vector COUNT burst.
  task automatic abort_burst();
    start = 1'b1;
    mode  = 2'd0;
    len   = LEN_W'(10);
    push_burst(2'd0, 10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      checkOutput("abort_valid", 32'(valid), 32'd1);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_quiet("abort_quiet");
    end
    checkOutput("abort_left", 32'(exp_q.size()), 32'd7);
    exp_q.delete();
    lfsr_m = SEED;
    rst    = 1'b0;
  endtask

  // Main sequence: reset, directed bursts, abort, then random bursts.
  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    mode   = 2'd0;
    len    = '0;
    lfsr_m = SEED;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_quiet("reset_quiet");
    end
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(2'd0, 5, 1'b0);
    applyStimulus(2'd1, 6, 1'b1);
    applyStimulus(2'd2, 3, 1'b0);
    applyStimulus(2'd2, 1, 1'b0);
    applyStimulus(2'($urandom), 0, 1'b0);
    applyStimulus(2'd0, 17, 1'b0);
    applyStimulus(2'd3, 4, 1'b0);
    abort_burst();
    applyStimulus(2'd0, 4, 1'b0);
    applyStimulus(2'd2, 2, 1'b0);
    applyStimulus(2'd0, 255, 1'b0);
    for (int n = 0; n < 40; n++) begin
      applyStimulus(2'($urandom), int'($urandom_range(0, 40)), 1'($urandom));
    end
    @(negedge clk);
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
